// File: rtl/dplca_txop_select.sv
// dplca_txop_select -- local TXOP ID scheduler for the DPLCA sublayer.
// On a rising edge of dplca_txop_table_upd the block walks the claim table
// through a synchronous read port and claims the first entry that is not
// HARD, publishing it as local_nodeID.
// Optional feature macro: DPLCA_RANDOM_START_EN (LFSR-chosen scan start ID).
module dplca_txop_select #(
  parameter int unsigned LOCAL_ID_MIN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dplca_en,
  input  logic       dplca_txop_table_upd,
  input  logic [7:0] max_id,
  input  logic       own_collision,
  output logic       tbl_rd_en,
  output logic [7:0] tbl_rd_addr,
  input  logic [1:0] tbl_rd_data,
  output logic [7:0] local_nodeID,
  output logic       id_valid,
  output logic       id_lost,
  output logic       scan_busy,
  output logic       no_free
);

  localparam logic [7:0] ID_MIN     = 8'(LOCAL_ID_MIN);
  localparam logic [1:0] ENTRY_HARD = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_UPD,
    S_SCAN,
    S_CLAIMED,
    S_FAIL
  } state_t;

  state_t     state_q, state_d;
  logic       upd_q;
  logic       upd_rise_q;
  logic [7:0] addr_q, addr_d;
  logic [8:0] remaining_q, remaining_d;   // reads still to issue this scan
  logic [7:0] max_q, max_d;               // max_id frozen at scan start
  logic       cmp_valid_q;                // a read was issued last cycle
  logic [7:0] cmp_addr_q;                 // address of that read
  logic [7:0] node_q, node_d;
  logic       id_valid_q, id_valid_d;
  logic       id_lost_q, id_lost_d;
  logic       no_free_q, no_free_d;
  logic [7:0] lost_id_q, lost_id_d;
  logic       lost_valid_q, lost_valid_d;

  logic       rd_en;
  logic       rise_window;
  logic       range_empty;
  logic [8:0] scan_len;
  logic [7:0] start_id;
  logic [7:0] addr_wrap;
  logic       cmp_hard;

`ifdef DPLCA_RANDOM_START_EN
  logic [7:0] lfsr_q;
  logic       lfsr_in_range;

  // Free-running Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign lfsr_in_range = (lfsr_q >= ID_MIN) && (lfsr_q <= max_id);
  assign start_id      = lfsr_in_range ? lfsr_q : ID_MIN;
`else
  assign start_id = ID_MIN;
`endif

  // Reads are issued only in SCAN and only while candidates remain, so a
  // full-table scan issues exactly one read per candidate.
  assign rd_en       = (state_q == S_SCAN) && (remaining_q != 9'd0);
  assign range_empty = (max_id < ID_MIN);
  assign scan_len    = {1'b0, max_id} - {1'b0, ID_MIN} + 9'd1;
  assign addr_wrap   = (addr_q == max_q) ? ID_MIN : addr_q + 8'd1;
  // The ID we just lost counts as HARD so the next scan steps past it.
  assign cmp_hard    = (tbl_rd_data == ENTRY_HARD) ||
                       (lost_valid_q && (cmp_addr_q == lost_id_q));
  // Update edges are only accepted when a scan may follow; edges seen in
  // CLAIMED (including one coinciding with own_collision) are dropped.
  assign rise_window = (state_q == S_WAIT_UPD) || (state_q == S_FAIL);

  // Registered rising-edge detector on the table-update strobe.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_q      <= 1'b0;
      upd_rise_q <= 1'b0;
    end else begin
      upd_q      <= dplca_txop_table_upd;
      upd_rise_q <= dplca_txop_table_upd & ~upd_q & dplca_en & rise_window;
    end
  end

  // State, scan bookkeeping and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      max_q        <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_addr_q   <= '0;
      node_q       <= '0;
      id_valid_q   <= 1'b0;
      id_lost_q    <= 1'b0;
      no_free_q    <= 1'b0;
      lost_id_q    <= '0;
      lost_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      max_q        <= max_d;
      cmp_valid_q  <= rd_en;
      cmp_addr_q   <= addr_q;
      node_q       <= node_d;
      id_valid_q   <= id_valid_d;
      id_lost_q    <= id_lost_d;
      no_free_q    <= no_free_d;
      lost_id_q    <= lost_id_d;
      lost_valid_q <= lost_valid_d;
    end
  end

  // Next-state logic: scan walk, claim, fail and collision handling.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    max_d        = max_q;
    node_d       = node_q;
    id_valid_d   = id_valid_q;
    id_lost_d    = 1'b0;
    no_free_d    = no_free_q;
    lost_id_d    = lost_id_q;
    lost_valid_d = lost_valid_q;

    if (!dplca_en) begin
      state_d      = S_IDLE;
      addr_d       = '0;
      remaining_d  = '0;
      node_d       = '0;
      id_valid_d   = 1'b0;
      no_free_d    = 1'b0;
      lost_id_d    = '0;
      lost_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_UPD;

        S_WAIT_UPD: begin
          if (upd_rise_q) begin
            if (range_empty) begin
              state_d      = S_FAIL;
              no_free_d    = 1'b1;
              lost_id_d    = '0;
              lost_valid_d = 1'b0;
            end else begin
              state_d     = S_SCAN;
              addr_d      = start_id;
              remaining_d = scan_len;
              max_d       = max_id;
              no_free_d   = 1'b0;
            end
          end
        end

        S_SCAN: begin
          if (rd_en) begin
            addr_d      = addr_wrap;
            remaining_d = remaining_q - 9'd1;
          end
          if (cmp_valid_q) begin
            if (!cmp_hard) begin
              state_d      = S_CLAIMED;
              node_d       = cmp_addr_q;
              id_valid_d   = 1'b1;
              lost_id_d    = '0;
              lost_valid_d = 1'b0;
            end else if (remaining_q == 9'd0) begin
              // The compare just made was for the last candidate.
              state_d      = S_FAIL;
              no_free_d    = 1'b1;
              lost_id_d    = '0;
              lost_valid_d = 1'b0;
            end
          end
        end

        S_CLAIMED: begin
          if (own_collision) begin
            state_d      = S_WAIT_UPD;
            id_valid_d   = 1'b0;
            id_lost_d    = 1'b1;
            lost_id_d    = node_q;
            lost_valid_d = 1'b1;
          end
        end

        S_FAIL: state_d = S_WAIT_UPD;

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign tbl_rd_en    = rd_en;
  assign tbl_rd_addr  = rd_en ? addr_q : 8'd0;
  assign local_nodeID = node_q;
  assign id_valid     = id_valid_q;
  assign id_lost      = id_lost_q;
  assign scan_busy    = (state_q == S_SCAN);
  assign no_free      = no_free_q;

endmodule

// File: tb/tb_dplca_txop_select.sv
// Self-checking bench for dplca_txop_select: a claim-table memory model,
// a read log, and a reference model that derives each scan's expected
// result, read sequence and latency from the candidate ordering.
module tb_dplca_txop_select;

  localparam int MIN = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       dplca_en;
  logic       upd;
  logic [7:0] max_id;
  logic       own_collision;
  logic       tbl_rd_en;
  logic [7:0] tbl_rd_addr;
  logic [1:0] tbl_rd_data = 2'b00;
  logic [7:0] local_nodeID;
  logic       id_valid;
  logic       id_lost;
  logic       scan_busy;
  logic       no_free;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] tbl [256];
  logic [7:0] rd_log [$];

  // Reference-model view of the scheduler.
  bit         m_claimed    = 1'b0;
  logic [7:0] m_id         = 8'd0;
  bit         m_lost_valid = 1'b0;
  logic [7:0] m_lost       = 8'd0;

  always #5 clk = ~clk;

  dplca_txop_select #(.LOCAL_ID_MIN(MIN)) dut (
    .clk                  (clk),
    .reset                (reset),
    .dplca_en             (dplca_en),
    .dplca_txop_table_upd (upd),
    .max_id               (max_id),
    .own_collision        (own_collision),
    .tbl_rd_en            (tbl_rd_en),
    .tbl_rd_addr          (tbl_rd_addr),
    .tbl_rd_data          (tbl_rd_data),
    .local_nodeID         (local_nodeID),
    .id_valid             (id_valid),
    .id_lost              (id_lost),
    .scan_busy            (scan_busy),
    .no_free              (no_free)
  );

  // Synchronous claim table plus a log of every issued read address.
  always @(posedge clk) begin
    if (tbl_rd_en) begin
      tbl_rd_data <= tbl[tbl_rd_addr];
      rd_log.push_back(tbl_rd_addr);
    end
  end

`ifdef DPLCA_RANDOM_START_EN
  logic [7:0] m_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in WAIT_UPD: a claimed ID blocks new scans, so cycle enable.
  task automatic go_wait_upd();
    if (m_claimed) begin
      dplca_en = 1'b0;
      step();
      dplca_en = 1'b1;
      step();
      m_claimed    = 1'b0;
      m_lost_valid = 1'b0;
    end
  endtask

  // Pulses the update strobe and checks the scan against the model.
  task automatic run_scan(input string name, input int forced_start);
    int         n, k, first_read, done_at, n_exp, start;
    bit         empty_rng, hit, reads_ok;
    logic [7:0] order [$];
    logic [7:0] c;

    rd_log.delete();
    upd = 1'b1;
    step();
    upd = 1'b0;

    start = MIN;
`ifdef DPLCA_RANDOM_START_EN
    if ((int'(m_lfsr) >= MIN) && (m_lfsr <= max_id)) start = int'(m_lfsr);
`endif
    if (forced_start >= 0) start = forced_start;

    n = int'(max_id) - MIN + 1;
    empty_rng = (n <= 0);
    hit = 1'b0;
    k = -1;
    for (int j = 0; j < n; j++) begin
      int cc;
      cc = start + j;
      if (cc > int'(max_id)) cc = cc - n;
      c = 8'(cc);
      order.push_back(c);
      if (!hit && tbl[c] != 2'b01 && !(m_lost_valid && c == m_lost)) begin
        hit = 1'b1;
        k = j;
      end
    end
    if (empty_rng)  n_exp = 0;
    else if (hit)   n_exp = (k + 2 < n) ? k + 2 : n;
    else            n_exp = n;

    first_read = -1;
    done_at    = -1;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (first_read < 0 && tbl_rd_en) begin
        first_read = i;
        n_checks++;
        if (scan_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s scan_busy: got %b expected 1 on first read", name, scan_busy);
        end
      end
      if (id_valid === 1'b1 || no_free === 1'b1) begin
        done_at = i;
        break;
      end
    end

    n_checks++;
    if (done_at < 0) begin
      n_fail++;
      $display("FAIL %s timeout: no id_valid/no_free within 400 cycles", name);
    end else if (empty_rng) begin
      if (rd_log.size() != 0 || done_at != 1 || no_free !== 1'b1 || id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s empty_range: reads=%0d done_at=%0d no_free=%b id_valid=%b expected 0 1 1 0",
                 name, rd_log.size(), done_at, no_free, id_valid);
      end
    end else begin
      if (hit) begin
        if (id_valid !== 1'b1 || no_free !== 1'b0 || local_nodeID !== order[k]) begin
          n_fail++;
          $display("FAIL %s claim: id_valid=%b no_free=%b id=%0d expected 1 0 %0d",
                   name, id_valid, no_free, local_nodeID, order[k]);
        end
        n_checks++;
        if (done_at - first_read != k + 2) begin
          n_fail++;
          $display("FAIL %s latency: got %0d expected %0d", name, done_at - first_read, k + 2);
        end
      end else begin
        if (no_free !== 1'b1 || id_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s no_free: no_free=%b id_valid=%b expected 1 0", name, no_free, id_valid);
        end
        n_checks++;
        if (done_at - first_read != n + 1) begin
          n_fail++;
          $display("FAIL %s fail_latency: got %0d expected %0d", name, done_at - first_read, n + 1);
        end
      end
      reads_ok = (rd_log.size() == n_exp);
      for (int j = 0; j < n_exp && reads_ok; j++)
        if (rd_log[j] !== order[j]) reads_ok = 1'b0;
      n_checks++;
      if (!reads_ok) begin
        n_fail++;
        $display("FAIL %s reads: got %0d reads first=%0d expected %0d reads first=%0d",
                 name, rd_log.size(), (rd_log.size() > 0) ? int'(rd_log[0]) : -1,
                 n_exp, int'(order[0]));
      end
    end

    m_lost_valid = 1'b0;
    m_claimed    = hit && !empty_rng;
    if (m_claimed) m_id = order[k];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dplca_en = 1'b0;
    upd = 1'b0;
    own_collision = 1'b0;
    max_id = 8'd0;
    for (int i = 0; i < 256; i++) tbl[i] = 2'b00;
    #12;
    n_checks++;
    if ({tbl_rd_en, tbl_rd_addr, local_nodeID, id_valid, id_lost, scan_busy, no_free} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {tbl_rd_en, tbl_rd_addr, local_nodeID, id_valid, id_lost, scan_busy, no_free});
    end
    dplca_en = 1'b1;
    upd = 1'b1;
    step();
    step();
    n_checks++;
    if ({tbl_rd_en, id_valid, scan_busy, no_free} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected 0000", {tbl_rd_en, id_valid, scan_busy, no_free});
    end
    upd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
  endtask

  task automatic test_free_found();
    go_wait_upd();
    max_id = 8'd8;
    for (int i = 1; i <= 8; i++) tbl[i] = (i <= 3) ? 2'b01 : 2'b00;
    run_scan("free_found", -1);
  endtask

  task automatic test_table_full();
    go_wait_upd();
    max_id = 8'd4;
    for (int i = 1; i <= 4; i++) tbl[i] = 2'b01;
    run_scan("table_full", -1);
    tbl[2] = 2'b00;
    run_scan("table_full_refill", -1);
  endtask

  task automatic test_empty_range();
    go_wait_upd();
    max_id = 8'd0;
    run_scan("empty_range", -1);
  endtask

  task automatic test_collision();
    bit saw_scan;
    go_wait_upd();
    max_id = 8'd8;
    for (int i = 1; i <= 8; i++) tbl[i] = (i <= 2) ? 2'b01 : 2'b00;
    run_scan("collision_claim", -1);
    own_collision = 1'b1;
    upd = 1'b1;
    step();
    own_collision = 1'b0;
    upd = 1'b0;
    n_checks++;
    if (id_lost !== 1'b1 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_pulse: id_lost=%b id_valid=%b expected 1 0", id_lost, id_valid);
    end
    step();
    n_checks++;
    if (id_lost !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_single: id_lost=%b expected 0", id_lost);
    end
    saw_scan = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (tbl_rd_en || scan_busy) saw_scan = 1'b1;
      step();
    end
    n_checks++;
    if (saw_scan) begin
      n_fail++;
      $display("FAIL collision_consumed: scan observed got 1 expected 0");
    end
    m_claimed    = 1'b0;
    m_lost_valid = 1'b1;
    m_lost       = m_id;
    run_scan("collision_rescan", -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      if (m_claimed && $urandom_range(0, 1) == 1) begin
        own_collision = 1'b1;
        step();
        own_collision = 1'b0;
        n_checks++;
        if (id_lost !== 1'b1) begin
          n_fail++;
          $display("FAIL random_collision: id_lost=%b expected 1", id_lost);
        end
        m_claimed    = 1'b0;
        m_lost_valid = 1'b1;
        m_lost       = m_id;
      end else begin
        go_wait_upd();
      end
      max_id = 8'($urandom_range(0, 24));
      for (int i = 0; i < 32; i++) begin
        if (it % 6 == 0 || $urandom_range(0, 3) != 0) tbl[i] = 2'b01;
        else case ($urandom_range(0, 2))
          0:       tbl[i] = 2'b00;
          1:       tbl[i] = 2'b10;
          default: tbl[i] = 2'b11;
        endcase
      end
      run_scan("random", -1);
    end
  endtask

  task automatic test_abort();
    go_wait_upd();
    max_id = 8'd20;
    for (int i = 1; i <= 20; i++) tbl[i] = 2'b01;
    upd = 1'b1;
    step();
    upd = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (tbl_rd_en !== 1'b1 || scan_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_midscan: rd_en=%b busy=%b expected 1 1", tbl_rd_en, scan_busy);
    end
    dplca_en = 1'b0;
    step();
    n_checks++;
    if ({tbl_rd_en, tbl_rd_addr, local_nodeID, id_valid, id_lost, scan_busy, no_free} !== 21'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %h expected 0",
               {tbl_rd_en, tbl_rd_addr, local_nodeID, id_valid, id_lost, scan_busy, no_free});
    end
    dplca_en = 1'b1;
    step();
    m_claimed    = 1'b0;
    m_lost_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    go_wait_upd();
    max_id = 8'd5;
    for (int i = 1; i <= 5; i++) tbl[i] = 2'b00;
    run_scan("pre_async_reset", -1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({tbl_rd_en, tbl_rd_addr, local_nodeID, id_valid, id_lost, scan_busy, no_free} !== 21'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0",
               {tbl_rd_en, tbl_rd_addr, local_nodeID, id_valid, id_lost, scan_busy, no_free});
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    m_claimed    = 1'b0;
    m_lost_valid = 1'b0;
    run_scan("post_async_reset", -1);
  endtask

`ifdef DPLCA_RANDOM_START_EN
  task automatic test_forced_start();
    go_wait_upd();
    max_id = 8'd6;
    for (int i = 1; i <= 6; i++) tbl[i] = (i == 2) ? 2'b00 : 2'b01;
    force dut.lfsr_q = 8'd6;
    run_scan("forced_start_wrap", 6);
    release dut.lfsr_q;
  endtask
`endif

  initial begin
    test_reset();
    test_free_found();
    test_table_full();
    test_empty_range();
    test_collision();
    test_random();
    test_abort();
    test_async_reset();
`ifdef DPLCA_RANDOM_START_EN
    test_forced_start();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
